axicb_slv_if: RTL and testbench
===============================

Name: axicb_slv_if

Overview:
- Slave-side interface of the crossbar: takes concatenated AW/W/AR channels from the switching logic and drives a native AXI slave port.
- Packs the slave's B/R responses back into concatenated channels toward the switch.
- Every channel passes through a 2-entry skid buffer.
- Per-direction outstanding-request counters throttle address acceptance to SLV_OSTDREQ_NUM.

Parameters:
- AXI_ADDR_W, 8, address width
- AXI_ID_W, 8, ID width
- AXI_DATA_W, 8, data width
- AXI_SIGNALING, 0, 0: AXI4-lite, 1: restricted AXI4 (len carried), 2: complete AXI4
- SLV_OSTDREQ_NUM, 4, max outstanding writes and, separately, max outstanding reads (>=1)
- AWCH_W / ARCH_W, 19, packed address channel width (mode-dependent)
- WCH_W, 9, {wstrb,wdata}
- BCH_W, 10, {bresp,bid}
- RCH_W, 18, {rresp,rdata,rid}

Ports:
- aclk  in  1  clock
- srst  in  1  synchronous active-high reset
- i_awvalid/i_awready  in/out  1  AW handshake from switch; i_awch  in  AWCH_W
- i_wvalid/i_wready  in/out  1; i_wlast  in  1; i_wch  in  WCH_W
- i_bvalid/i_bready  out/in  1; i_bch  out  BCH_W
- i_arvalid/i_arready  in/out  1; i_arch  in  ARCH_W
- i_rvalid/i_rready  out/in  1; i_rlast  out  1; i_rch  out  RCH_W
- o_awvalid/o_awready  out/in  1; o_awaddr  out  AXI_ADDR_W; o_awid  out  AXI_ID_W; o_awlen  out  8; o_awsize  out  3; o_awburst  out  2; o_awlock  out  2; o_awcache/o_awqos/o_awregion  out  4 each; o_awprot  out  3
- o_wvalid/o_wready  out/in  1; o_wlast  out  1; o_wdata  out  AXI_DATA_W; o_wstrb  out  AXI_DATA_W/8
- o_bvalid/o_bready  in/out  1; o_bid  in  AXI_ID_W; o_bresp  in  2
- o_arvalid/o_arready and o_ar* fields: same set and widths as AW
- o_rvalid/o_rready  in/out  1; o_rid  in  AXI_ID_W; o_rresp  in  2; o_rdata  in  AXI_DATA_W; o_rlast  in  1
- wr_ostd, rd_ostd  out  $clog2(SLV_OSTDREQ_NUM+1)  outstanding counts
- err  out  1  sticky protocol error

Behaviour:
- Clocking/reset: single clock aclk; srst is synchronous, active-high.
- Reset state: all valids 0, all readies 0, counters 0, err 0, skid contents discarded. Readies rise the cycle after srst deasserts. srst mid-operation drops buffered beats and zeroes counters.
- Packing, address channels (LSB first):
  - mode 0: {id,prot,addr}
  - mode 1: {id,prot,len,addr}
  - mode 2: {id,region,qos,prot,cache,lock,burst,size,len,addr}
- Packing, other channels: wch={wstrb,wdata}; bch={bresp,bid}; rch={rresp,rdata,rid}.
- Unused AXI fields:
  - len=0 in mode 0
  - size=$clog2(AXI_DATA_W/8) in modes 0/1
  - burst=2'b01 (INCR) in modes 0/1
  - lock/cache/qos/region=0 in modes 0/1
- Skid buffer (each of 5 channels):
  - 2 entries; output valid is registered; 1-cycle latency from input handshake to output valid.
  - Sustains 1 beat/cycle under continuous ready.
  - Ready = registered "not full"; it deasserts only when both entries are held.
  - Output data is stable while valid && !ready.
  - Beats are never dropped or reordered.
- Write counter:
  - wr_ostd increments on i_awvalid&i_awready; decrements on i_bvalid&i_bready.
  - Simultaneous increment and decrement: count unchanged.
  - i_awready = aw_buffer_not_full && (wr_ostd < SLV_OSTDREQ_NUM).
- Read counter: same rules using i_arvalid&i_arready and i_rvalid&i_rready&i_rlast.
- W channel: not gated by the counter.
- Error: a B or R-last accepted from the slave (o_bvalid&o_bready, o_rvalid&o_rready&o_rlast) while the matching counter is 0 (no response pending or buffered) sets err. err stays set until srst; the counter saturates at 0 (no underflow).

Test Plan:
- Reset: srst held 3 cycles -> all valids/readies 0, wr_ostd=rd_ostd=0, err=0; one cycle after release, i_awready=i_wready=i_arready=1.
- Mode 0 AW: i_awch={id 8'h5A, prot 3'h2, addr 8'h3C} -> next cycle o_awvalid=1, o_awaddr=8'h3C, o_awprot=2, o_awid=8'h5A, o_awlen=0, o_awburst=1, o_awsize=0; wr_ostd=1.
- Throttle: 4 AWs accepted, no B -> i_awready=0, wr_ostd=4. One B handshake -> the next AW is accepted; wr_ostd returns to 4.
- Backpressure: 10 W beats streamed with o_wready toggling 1,0,0,1 -> all 10 beats arrive in order with no duplication; i_wready drops only when both entries are held.
- Simultaneous: AR accept and R-last return in the same cycle at rd_ostd=2 -> rd_ostd stays 2. rd_ostd tracks correctly across a 4-beat burst with only the last beat counted (mode 1, len=3).
- Error: o_bvalid=1 with wr_ostd=0 -> err=1, wr_ostd=0; err stays set until srst.

Source files
------------

// File: rtl/axicb_slv_if.sv
// Slave-side crossbar interface: unpacks switch channels onto a native AXI slave port,
// packs B/R back toward the switch, and throttles addresses by outstanding-request count.

module axicb_skid #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         srst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wptr, rptr;
  logic [1:0]   cnt, cnt_nxt;
  logic         push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Both flags come from next occupancy so they are plain flops with no comb path.
  always_ff @(posedge aclk) begin
    if (srst) begin
      cnt       <= 2'd0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      in_ready  <= (cnt_nxt != 2'd2);
      out_valid <= (cnt_nxt != 2'd0);
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wptr] <= in_data;
  end

  assign out_data = mem[rptr];

endmodule

module axicb_achan #(
  parameter int ADDR_W = 8,
  parameter int ID_W   = 8,
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  parameter int CH_W   = 19
) (
  input  logic [CH_W-1:0]   ch,
  output logic [ADDR_W-1:0] addr,
  output logic [ID_W-1:0]   id,
  output logic [7:0]        len,
  output logic [2:0]        size,
  output logic [1:0]        burst,
  output logic [1:0]        lock,
  output logic [3:0]        cache,
  output logic [3:0]        qos,
  output logic [3:0]        region,
  output logic [2:0]        prot
);

  localparam logic [2:0] SIZE_DEF = 3'($clog2(DATA_W/8));
  localparam int A = ADDR_W;

  assign addr = ch[0 +: ADDR_W];

  generate
    if (MODE == 0) begin : g_lite
      assign prot   = ch[A +: 3];
      assign id     = ch[A+3 +: ID_W];
      assign len    = 8'd0;
      assign size   = SIZE_DEF;
      assign burst  = 2'b01;
      assign lock   = 2'd0;
      assign cache  = 4'd0;
      assign qos    = 4'd0;
      assign region = 4'd0;
    end else if (MODE == 1) begin : g_len
      assign len    = ch[A +: 8];
      assign prot   = ch[A+8 +: 3];
      assign id     = ch[A+11 +: ID_W];
      assign size   = SIZE_DEF;
      assign burst  = 2'b01;
      assign lock   = 2'd0;
      assign cache  = 4'd0;
      assign qos    = 4'd0;
      assign region = 4'd0;
    end else begin : g_full
      assign len    = ch[A +: 8];
      assign size   = ch[A+8 +: 3];
      assign burst  = ch[A+11 +: 2];
      assign lock   = ch[A+13 +: 2];
      assign cache  = ch[A+15 +: 4];
      assign prot   = ch[A+19 +: 3];
      assign qos    = ch[A+22 +: 4];
      assign region = ch[A+26 +: 4];
      assign id     = ch[A+30 +: ID_W];
    end
  endgenerate

endmodule

module axicb_slv_if #(
  parameter int AXI_ADDR_W      = 8,
  parameter int AXI_ID_W        = 8,
  parameter int AXI_DATA_W      = 8,
  parameter int AXI_SIGNALING   = 0,
  parameter int SLV_OSTDREQ_NUM = 4,
  parameter int AWCH_W = (AXI_SIGNALING == 0) ? AXI_ID_W + 3 + AXI_ADDR_W :
                         (AXI_SIGNALING == 1) ? AXI_ID_W + 11 + AXI_ADDR_W :
                                                AXI_ID_W + 30 + AXI_ADDR_W,
  parameter int ARCH_W = AWCH_W,
  parameter int WCH_W  = AXI_DATA_W/8 + AXI_DATA_W,
  parameter int BCH_W  = 2 + AXI_ID_W,
  parameter int RCH_W  = 2 + AXI_DATA_W + AXI_ID_W,
  localparam int CNT_W = $clog2(SLV_OSTDREQ_NUM+1)
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic                    i_awvalid,
  output logic                    i_awready,
  input  logic [AWCH_W-1:0]       i_awch,
  input  logic                    i_wvalid,
  output logic                    i_wready,
  input  logic                    i_wlast,
  input  logic [WCH_W-1:0]        i_wch,
  output logic                    i_bvalid,
  input  logic                    i_bready,
  output logic [BCH_W-1:0]        i_bch,
  input  logic                    i_arvalid,
  output logic                    i_arready,
  input  logic [ARCH_W-1:0]       i_arch,
  output logic                    i_rvalid,
  input  logic                    i_rready,
  output logic                    i_rlast,
  output logic [RCH_W-1:0]        i_rch,
  output logic                    o_awvalid,
  input  logic                    o_awready,
  output logic [AXI_ADDR_W-1:0]   o_awaddr,
  output logic [AXI_ID_W-1:0]     o_awid,
  output logic [7:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic [1:0]              o_awlock,
  output logic [3:0]              o_awcache,
  output logic [3:0]              o_awqos,
  output logic [3:0]              o_awregion,
  output logic [2:0]              o_awprot,
  output logic                    o_wvalid,
  input  logic                    o_wready,
  output logic                    o_wlast,
  output logic [AXI_DATA_W-1:0]   o_wdata,
  output logic [AXI_DATA_W/8-1:0] o_wstrb,
  input  logic                    o_bvalid,
  output logic                    o_bready,
  input  logic [AXI_ID_W-1:0]     o_bid,
  input  logic [1:0]              o_bresp,
  output logic                    o_arvalid,
  input  logic                    o_arready,
  output logic [AXI_ADDR_W-1:0]   o_araddr,
  output logic [AXI_ID_W-1:0]     o_arid,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic [1:0]              o_arlock,
  output logic [3:0]              o_arcache,
  output logic [3:0]              o_arqos,
  output logic [3:0]              o_arregion,
  output logic [2:0]              o_arprot,
  input  logic                    o_rvalid,
  output logic                    o_rready,
  input  logic [AXI_ID_W-1:0]     o_rid,
  input  logic [1:0]              o_rresp,
  input  logic [AXI_DATA_W-1:0]   o_rdata,
  input  logic                    o_rlast,
  output logic [CNT_W-1:0]        wr_ostd,
  output logic [CNT_W-1:0]        rd_ostd,
  output logic                    err
);

  localparam logic [CNT_W-1:0] OSTD_MAX = CNT_W'(SLV_OSTDREQ_NUM);

  logic              wr_ok, rd_ok;
  logic              aw_rdy, ar_rdy;
  logic [AWCH_W-1:0] aw_q;
  logic [ARCH_W-1:0] ar_q;
  logic              wr_inc, wr_dec, rd_inc, rd_dec;
  logic              b_orphan, r_orphan;

  assign wr_ok     = (wr_ostd < OSTD_MAX);
  assign rd_ok     = (rd_ostd < OSTD_MAX);
  assign i_awready = aw_rdy && wr_ok;
  assign i_arready = ar_rdy && rd_ok;

  axicb_skid #(.W(AWCH_W)) u_aw (
    .aclk(aclk), .srst(srst),
    .in_valid(i_awvalid && wr_ok), .in_ready(aw_rdy), .in_data(i_awch),
    .out_valid(o_awvalid), .out_ready(o_awready), .out_data(aw_q)
  );

  axicb_skid #(.W(WCH_W+1)) u_w (
    .aclk(aclk), .srst(srst),
    .in_valid(i_wvalid), .in_ready(i_wready), .in_data({i_wlast, i_wch}),
    .out_valid(o_wvalid), .out_ready(o_wready), .out_data({o_wlast, o_wstrb, o_wdata})
  );

  axicb_skid #(.W(BCH_W)) u_b (
    .aclk(aclk), .srst(srst),
    .in_valid(o_bvalid), .in_ready(o_bready), .in_data({o_bresp, o_bid}),
    .out_valid(i_bvalid), .out_ready(i_bready), .out_data(i_bch)
  );

  axicb_skid #(.W(ARCH_W)) u_ar (
    .aclk(aclk), .srst(srst),
    .in_valid(i_arvalid && rd_ok), .in_ready(ar_rdy), .in_data(i_arch),
    .out_valid(o_arvalid), .out_ready(o_arready), .out_data(ar_q)
  );

  axicb_skid #(.W(RCH_W+1)) u_r (
    .aclk(aclk), .srst(srst),
    .in_valid(o_rvalid), .in_ready(o_rready), .in_data({o_rlast, o_rresp, o_rdata, o_rid}),
    .out_valid(i_rvalid), .out_ready(i_rready), .out_data({i_rlast, i_rch})
  );

  axicb_achan #(.ADDR_W(AXI_ADDR_W), .ID_W(AXI_ID_W), .DATA_W(AXI_DATA_W),
                .MODE(AXI_SIGNALING), .CH_W(AWCH_W)) u_aw_unpack (
    .ch(aw_q), .addr(o_awaddr), .id(o_awid), .len(o_awlen), .size(o_awsize),
    .burst(o_awburst), .lock(o_awlock), .cache(o_awcache), .qos(o_awqos),
    .region(o_awregion), .prot(o_awprot)
  );

  axicb_achan #(.ADDR_W(AXI_ADDR_W), .ID_W(AXI_ID_W), .DATA_W(AXI_DATA_W),
                .MODE(AXI_SIGNALING), .CH_W(ARCH_W)) u_ar_unpack (
    .ch(ar_q), .addr(o_araddr), .id(o_arid), .len(o_arlen), .size(o_arsize),
    .burst(o_arburst), .lock(o_arlock), .cache(o_arcache), .qos(o_arqos),
    .region(o_arregion), .prot(o_arprot)
  );

  // A stray response still flows to the switch; the counter just refuses to go below 0.
  assign wr_inc = i_awvalid && i_awready;
  assign wr_dec = i_bvalid && i_bready && (wr_ostd != '0);
  assign rd_inc = i_arvalid && i_arready;
  assign rd_dec = i_rvalid && i_rready && i_rlast && (rd_ostd != '0);

  assign b_orphan = o_bvalid && o_bready && (wr_ostd == '0);
  assign r_orphan = o_rvalid && o_rready && o_rlast && (rd_ostd == '0);

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ostd <= '0;
      rd_ostd <= '0;
      err     <= 1'b0;
    end else begin
      case ({wr_inc, wr_dec})
        2'b10:   wr_ostd <= wr_ostd + 1'b1;
        2'b01:   wr_ostd <= wr_ostd - 1'b1;
        default: wr_ostd <= wr_ostd;
      endcase
      case ({rd_inc, rd_dec})
        2'b10:   rd_ostd <= rd_ostd + 1'b1;
        2'b01:   rd_ostd <= rd_ostd - 1'b1;
        default: rd_ostd <= rd_ostd;
      endcase
      if (b_orphan || r_orphan) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axicb_slv_if.sv
// Directed bench for axicb_slv_if: mode-0 instance for most traffic, mode-1 instance
// for a len-carrying read burst.

module tb_axicb_slv_if;

  logic aclk = 1'b0;
  logic srst;
  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode-0 instance
  logic        i_awvalid, i_awready, i_wvalid, i_wready, i_wlast;
  logic [18:0] i_awch, i_arch;
  logic [8:0]  i_wch;
  logic        i_bvalid, i_bready, i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [9:0]  i_bch;
  logic [17:0] i_rch;
  logic        o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, o_bvalid, o_bready;
  logic [7:0]  o_awaddr, o_awid, o_awlen, o_wdata, o_bid, o_araddr, o_arid, o_arlen;
  logic [2:0]  o_awsize, o_awprot, o_arsize, o_arprot;
  logic [1:0]  o_awburst, o_awlock, o_arburst, o_arlock, o_bresp, o_rresp;
  logic [3:0]  o_awcache, o_awqos, o_awregion, o_arcache, o_arqos, o_arregion;
  logic [0:0]  o_wstrb;
  logic        o_arvalid, o_arready, o_rvalid, o_rready, o_rlast;
  logic [7:0]  o_rid, o_rdata;
  logic [2:0]  wr_ostd, rd_ostd;
  logic        err;

  axicb_slv_if u_dut (
    .aclk(aclk), .srst(srst),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awaddr(o_awaddr), .o_awid(o_awid),
    .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst), .o_awlock(o_awlock),
    .o_awcache(o_awcache), .o_awqos(o_awqos), .o_awregion(o_awregion), .o_awprot(o_awprot),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bid(o_bid), .o_bresp(o_bresp),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_araddr(o_araddr), .o_arid(o_arid),
    .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arlock(o_arlock),
    .o_arcache(o_arcache), .o_arqos(o_arqos), .o_arregion(o_arregion), .o_arprot(o_arprot),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rid(o_rid), .o_rresp(o_rresp),
    .o_rdata(o_rdata), .o_rlast(o_rlast),
    .wr_ostd(wr_ostd), .rd_ostd(rd_ostd), .err(err)
  );

  // mode-1 instance
  logic        m_i_awvalid, m_i_awready, m_i_wvalid, m_i_wready, m_i_wlast;
  logic [26:0] m_i_awch, m_i_arch;
  logic [8:0]  m_i_wch;
  logic        m_i_bvalid, m_i_bready, m_i_arvalid, m_i_arready, m_i_rvalid, m_i_rready, m_i_rlast;
  logic [9:0]  m_i_bch;
  logic [17:0] m_i_rch;
  logic        m_o_awvalid, m_o_awready, m_o_wvalid, m_o_wready, m_o_wlast, m_o_bvalid, m_o_bready;
  logic [7:0]  m_o_awaddr, m_o_awid, m_o_awlen, m_o_wdata, m_o_bid, m_o_araddr, m_o_arid, m_o_arlen;
  logic [2:0]  m_o_awsize, m_o_awprot, m_o_arsize, m_o_arprot;
  logic [1:0]  m_o_awburst, m_o_awlock, m_o_arburst, m_o_arlock, m_o_bresp, m_o_rresp;
  logic [3:0]  m_o_awcache, m_o_awqos, m_o_awregion, m_o_arcache, m_o_arqos, m_o_arregion;
  logic [0:0]  m_o_wstrb;
  logic        m_o_arvalid, m_o_arready, m_o_rvalid, m_o_rready, m_o_rlast;
  logic [7:0]  m_o_rid, m_o_rdata;
  logic [2:0]  m_wr_ostd, m_rd_ostd;
  logic        m_err;

  axicb_slv_if #(.AXI_SIGNALING(1)) u_dut1 (
    .aclk(aclk), .srst(srst),
    .i_awvalid(m_i_awvalid), .i_awready(m_i_awready), .i_awch(m_i_awch),
    .i_wvalid(m_i_wvalid), .i_wready(m_i_wready), .i_wlast(m_i_wlast), .i_wch(m_i_wch),
    .i_bvalid(m_i_bvalid), .i_bready(m_i_bready), .i_bch(m_i_bch),
    .i_arvalid(m_i_arvalid), .i_arready(m_i_arready), .i_arch(m_i_arch),
    .i_rvalid(m_i_rvalid), .i_rready(m_i_rready), .i_rlast(m_i_rlast), .i_rch(m_i_rch),
    .o_awvalid(m_o_awvalid), .o_awready(m_o_awready), .o_awaddr(m_o_awaddr), .o_awid(m_o_awid),
    .o_awlen(m_o_awlen), .o_awsize(m_o_awsize), .o_awburst(m_o_awburst), .o_awlock(m_o_awlock),
    .o_awcache(m_o_awcache), .o_awqos(m_o_awqos), .o_awregion(m_o_awregion), .o_awprot(m_o_awprot),
    .o_wvalid(m_o_wvalid), .o_wready(m_o_wready), .o_wlast(m_o_wlast), .o_wdata(m_o_wdata), .o_wstrb(m_o_wstrb),
    .o_bvalid(m_o_bvalid), .o_bready(m_o_bready), .o_bid(m_o_bid), .o_bresp(m_o_bresp),
    .o_arvalid(m_o_arvalid), .o_arready(m_o_arready), .o_araddr(m_o_araddr), .o_arid(m_o_arid),
    .o_arlen(m_o_arlen), .o_arsize(m_o_arsize), .o_arburst(m_o_arburst), .o_arlock(m_o_arlock),
    .o_arcache(m_o_arcache), .o_arqos(m_o_arqos), .o_arregion(m_o_arregion), .o_arprot(m_o_arprot),
    .o_rvalid(m_o_rvalid), .o_rready(m_o_rready), .o_rid(m_o_rid), .o_rresp(m_o_rresp),
    .o_rdata(m_o_rdata), .o_rlast(m_o_rlast),
    .wr_ostd(m_wr_ostd), .rd_ostd(m_rd_ostd), .err(m_err)
  );

  logic [3:0] wr_pat = 4'b1001;  // o_wready per cycle: 1,0,0,1

  initial begin
    int idx, rcv, cyc, occ;
    logic in_hs, out_hs;

    srst = 1'b1;
    i_awvalid = 0; i_awch = '0; i_wvalid = 0; i_wlast = 0; i_wch = '0; i_bready = 1;
    i_arvalid = 0; i_arch = '0; i_rready = 0;
    o_awready = 0; o_wready = 0; o_bvalid = 0; o_bid = '0; o_bresp = '0;
    o_arready = 0; o_rvalid = 0; o_rid = '0; o_rresp = '0; o_rdata = '0; o_rlast = 0;
    m_i_awvalid = 0; m_i_awch = '0; m_i_wvalid = 0; m_i_wlast = 0; m_i_wch = '0; m_i_bready = 1;
    m_i_arvalid = 0; m_i_arch = '0; m_i_rready = 1;
    m_o_awready = 1; m_o_wready = 1; m_o_bvalid = 0; m_o_bid = '0; m_o_bresp = '0;
    m_o_arready = 1; m_o_rvalid = 0; m_o_rid = '0; m_o_rresp = '0; m_o_rdata = '0; m_o_rlast = 0;

    // reset
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", i_awready, 0);
    chk("rst_wready", i_wready, 0);
    chk("rst_arready", i_arready, 0);
    chk("rst_bready", o_bready, 0);
    chk("rst_valids", {o_awvalid, o_wvalid, o_arvalid, i_bvalid, i_rvalid}, 0);
    chk("rst_ostd", {wr_ostd, rd_ostd}, 0);
    chk("rst_err", err, 0);
    srst = 1'b0;
    @(negedge aclk);
    chk("rel_readies", {i_awready, i_wready, i_arready, o_bready, o_rready}, 5'b11111);

    // mode-0 AW unpack
    i_awvalid = 1; i_awch = {8'h5A, 3'h2, 8'h3C};
    @(negedge aclk);
    i_awvalid = 0;
    chk("aw_valid", o_awvalid, 1);
    chk("aw_addr", o_awaddr, 8'h3C);
    chk("aw_prot", o_awprot, 3'h2);
    chk("aw_id", o_awid, 8'h5A);
    chk("aw_len", o_awlen, 0);
    chk("aw_burst", o_awburst, 2'b01);
    chk("aw_size", o_awsize, 0);
    chk("aw_misc", {o_awlock, o_awcache, o_awqos, o_awregion}, 0);
    chk("aw_ostd1", wr_ostd, 1);

    // throttle at 4 outstanding writes
    o_awready = 1;
    for (int k = 1; k <= 3; k++) begin
      i_awvalid = 1; i_awch = {8'h10 + 8'(k), 3'h0, 8'h80 + 8'(k)};
      @(negedge aclk);
    end
    i_awch = {8'h14, 3'h1, 8'h84};
    chk("thr_ostd4", wr_ostd, 4);
    chk("thr_awready0", i_awready, 0);
    @(negedge aclk);
    chk("thr_hold", wr_ostd, 4);
    o_bvalid = 1; o_bid = 8'h5A; o_bresp = 2'b10;
    @(negedge aclk);
    o_bvalid = 0;
    chk("b_valid", i_bvalid, 1);
    chk("b_ch", i_bch, {2'b10, 8'h5A});
    chk("b_awready0", i_awready, 0);
    @(negedge aclk);
    chk("b_ostd3", wr_ostd, 3);
    chk("b_awready1", i_awready, 1);
    @(negedge aclk);
    i_awvalid = 0;
    chk("thr_ostd4b", wr_ostd, 4);
    chk("thr_aw5_addr", o_awaddr, 8'h84);
    chk("thr_aw5_id", o_awid, 8'h14);

    // simultaneous AR accept and R-last return at rd_ostd=2
    o_arready = 1;
    i_arvalid = 1; i_arch = {8'h21, 3'h0, 8'h90};
    @(negedge aclk);
    i_arch = {8'h22, 3'h0, 8'h94};
    @(negedge aclk);
    i_arvalid = 0;
    chk("rd_ostd2", rd_ostd, 2);
    o_rvalid = 1; o_rlast = 1; o_rid = 8'h21; o_rresp = 2'b00; o_rdata = 8'hC3;
    @(negedge aclk);
    o_rvalid = 0;
    chk("r_valid", {i_rvalid, i_rlast}, 2'b11);
    chk("r_ch", i_rch, {2'b00, 8'hC3, 8'h21});
    i_rready = 1; i_arvalid = 1; i_arch = {8'h23, 3'h0, 8'h98};
    @(negedge aclk);
    i_arvalid = 0;
    chk("sim_ostd2", rd_ostd, 2);
    chk("sim_rvalid0", i_rvalid, 0);
    chk("sim_err", err, 0);

    // W backpressure: occupancy model predicts when i_wready must drop
    idx = 0; rcv = 0; cyc = 0; occ = 0;
    while (rcv < 10 && cyc < 200) begin
      chk("w_ready", i_wready, (occ != 2));
      o_wready = wr_pat[cyc % 4];
      i_wvalid = (idx < 10);
      i_wch = {1'b1, 8'h10 + 8'(idx)};
      i_wlast = (idx == 9);
      #1;
      in_hs = i_wvalid && i_wready;
      out_hs = o_wvalid && o_wready;
      if (out_hs) begin
        chk("w_data", o_wdata, 8'h10 + 8'(rcv));
        chk("w_last", o_wlast, (rcv == 9));
        rcv++;
      end
      occ = occ + int'(in_hs) - int'(out_hs);
      if (in_hs) idx++;
      cyc++;
      @(negedge aclk);
    end
    i_wvalid = 0; i_wlast = 0;
    chk("w_count", rcv, 10);

    // srst mid-operation drops buffered beats and clears counters
    o_wready = 0;
    i_wvalid = 1; i_wch = 9'h1AA;
    @(negedge aclk);
    i_wvalid = 0;
    chk("mid_wvalid", o_wvalid, 1);
    srst = 1;
    @(negedge aclk);
    srst = 0;
    chk("mid_wdrop", o_wvalid, 0);
    chk("mid_ostd", {wr_ostd, rd_ostd}, 0);
    @(negedge aclk);

    // orphan B sets sticky err, counter stays at 0
    o_bvalid = 1; o_bid = 8'h33; o_bresp = 2'b00;
    @(negedge aclk);
    o_bvalid = 0;
    chk("err_set", err, 1);
    chk("err_ostd", wr_ostd, 0);
    repeat (3) @(negedge aclk);
    chk("err_sticky", err, 1);
    chk("err_sat", wr_ostd, 0);
    srst = 1;
    @(negedge aclk);
    srst = 0;
    chk("err_clr", err, 0);
    @(negedge aclk);

    // mode-1 AR with len=3, then a 4-beat R burst: only the last beat retires it
    m_i_arvalid = 1; m_i_arch = {8'hA7, 3'h5, 8'd3, 8'h40};
    @(negedge aclk);
    m_i_arvalid = 0;
    chk("m1_arvalid", m_o_arvalid, 1);
    chk("m1_arlen", m_o_arlen, 3);
    chk("m1_araddr", m_o_araddr, 8'h40);
    chk("m1_arprot", m_o_arprot, 3'h5);
    chk("m1_arid", m_o_arid, 8'hA7);
    chk("m1_arburst", {m_o_arburst, m_o_arsize}, {2'b01, 3'd0});
    chk("m1_ostd1", m_rd_ostd, 1);
    for (int b = 0; b < 4; b++) begin
      m_o_rvalid = 1; m_o_rlast = (b == 3); m_o_rid = 8'hA7; m_o_rdata = 8'h60 + 8'(b);
      @(negedge aclk);
      chk("m1_burst_ostd", m_rd_ostd, 1);
    end
    m_o_rvalid = 0; m_o_rlast = 0;
    @(negedge aclk);
    chk("m1_done_ostd", m_rd_ostd, 0);
    chk("m1_err", m_err, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
